// File: rtl/hawk_att_upd_pkg.sv
// Shared definitions for the ATT read-modify-write engine: table base,
// AttEntry field layout, id width helper and line/slot address helpers.
package hawk_att_upd_pkg;

  localparam int          ATT_ENTRY_MAX  = 1024;
  localparam logic [63:0] HAWK_ATT_START = 64'h0000_0000_8000_0000;

  // AttEntry layout: status nibble at the bottom, way byte right above it.
  localparam int ATT_STS_LSB = 0;
  localparam int ATT_STS_W   = 4;
  localparam int ATT_WAY_LSB = 4;
  localparam int ATT_WAY_W   = 8;

  typedef struct packed {
    logic [51:0] rsvd;
    logic [7:0]  way;
    logic [3:0]  sts;
  } att_entry_t;

  // Number of bits needed to hold 'value' itself (ids are 1-based).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int ATT_ID_BITS = clogb2(ATT_ENTRY_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B,
    ST_DONE
  } att_state_e;

  // Eight 64-bit entries per 64-byte line; ids start at 1.
  function automatic logic [63:0] att_line_addr(input logic [ATT_ID_BITS-1:0] id);
    logic [ATT_ID_BITS-1:0] idx;
    idx = id - ATT_ID_BITS'(1);
    return HAWK_ATT_START + (64'(idx >> 3) << 6);
  endfunction

  function automatic logic [2:0] att_slot(input logic [ATT_ID_BITS-1:0] id);
    logic [ATT_ID_BITS-1:0] idx;
    idx = id - ATT_ID_BITS'(1);
    return idx[2:0];
  endfunction

endpackage

// File: rtl/hawk_att_merge.sv
// Combinational merge of one AttEntry's sts/way fields into a cache line,
// plus the byte strobe covering the touched 64-bit slot.
module hawk_att_merge
  import hawk_att_upd_pkg::*;
#(
  parameter int DATA_W = 512
) (
  input  logic [DATA_W-1:0]   line_i,
  input  logic [2:0]          slot_i,
  input  logic [63:0]         entry_i,
  input  logic                sts_we_i,
  input  logic                way_we_i,
  output logic [DATA_W-1:0]   line_o,
  output logic [DATA_W/8-1:0] strb_o
);

  localparam logic [63:0] STS_MASK = ((64'd1 << ATT_STS_W) - 64'd1) << ATT_STS_LSB;
  localparam logic [63:0] WAY_MASK = ((64'd1 << ATT_WAY_W) - 64'd1) << ATT_WAY_LSB;

  logic [63:0] slot_old;
  logic [63:0] slot_new;

  // Replace only the enabled fields; everything else passes through.
  always_comb begin
    line_o   = line_i;
    strb_o   = '0;
    slot_old = line_i[64*slot_i +: 64];
    slot_new = slot_old;
    if (sts_we_i) slot_new = (slot_new & ~STS_MASK) | (entry_i & STS_MASK);
    if (way_we_i) slot_new = (slot_new & ~WAY_MASK) | (entry_i & WAY_MASK);
    line_o[64*slot_i +: 64] = slot_new;
    strb_o[8*slot_i +: 8]   = 8'hFF;
  end

endmodule

// File: rtl/hawk_att_upd.sv
// ATT entry read-modify-write engine: fetch line, merge sts/way, write back.
// Optional macro HAWK_ATT_UPD_LINE_CACHE_EN keeps the last written line so a
// request to the same line skips the AXI read.
module hawk_att_upd
  import hawk_att_upd_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ATT_ID_W = ATT_ID_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ATT_ID_W-1:0] req_att_id_i,
  input  logic [63:0]         req_entry_i,
  input  logic                req_sts_we_i,
  input  logic                req_way_we_i,
  output logic                done_o,
  output logic                err_o,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  output logic [ADDR_W-1:0]   ar_addr_o,
  input  logic                r_valid_i,
  output logic                r_ready_o,
  input  logic [DATA_W-1:0]   r_data_i,
  input  logic [1:0]          r_resp_i,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  output logic [ADDR_W-1:0]   aw_addr_o,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [DATA_W-1:0]   w_data_o,
  output logic [DATA_W/8-1:0] w_strb_o,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [1:0]          b_resp_i
);

  att_state_e            state_q, state_d;
  logic [ATT_ID_W-1:0]   id_q;
  logic [63:0]           entry_q;
  logic                  sts_we_q, way_we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     line_q;
  logic [DATA_W/8-1:0]   strb_q;
  logic                  aw_pend_q, w_pend_q;
  logic                  err_q;
  logic                  cache_hit;

  logic [DATA_W-1:0]     mrg_line_in, mrg_line;
  logic [DATA_W/8-1:0]   mrg_strb;
  logic [2:0]            mrg_slot;
  logic [63:0]           mrg_entry;
  logic                  mrg_sts_we, mrg_way_we;

`ifdef HAWK_ATT_UPD_LINE_CACHE_EN
  logic                  cache_vld_q;
  logic [ADDR_W-1:0]     cache_addr_q;
  logic [DATA_W-1:0]     cache_line_q;

  assign cache_hit = cache_vld_q &&
                     (cache_addr_q == ADDR_W'(att_line_addr(req_att_id_i)));

  // Remember the last successfully written line; any error response invalidates it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_line_q <= '0;
    end else if (state_q == ST_R && r_valid_i && r_resp_i != 2'b00) begin
      cache_vld_q <= 1'b0;
    end else if (state_q == ST_B && b_valid_i) begin
      if (b_resp_i == 2'b00) begin
        cache_vld_q  <= 1'b1;
        cache_addr_q <= addr_q;
        cache_line_q <= line_q;
      end else begin
        cache_vld_q <= 1'b0;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Merge source: the incoming request on a cache hit in IDLE, otherwise the latched request and the read beat.
  always_comb begin
    mrg_line_in = r_data_i;
    mrg_slot    = att_slot(id_q);
    mrg_entry   = entry_q;
    mrg_sts_we  = sts_we_q;
    mrg_way_we  = way_we_q;
`ifdef HAWK_ATT_UPD_LINE_CACHE_EN
    if (state_q == ST_IDLE) begin
      mrg_line_in = cache_line_q;
      mrg_slot    = att_slot(req_att_id_i);
      mrg_entry   = req_entry_i;
      mrg_sts_we  = req_sts_we_i;
      mrg_way_we  = req_way_we_i;
    end
`endif
  end

  hawk_att_merge #(.DATA_W(DATA_W)) u_merge (
    .line_i   (mrg_line_in),
    .slot_i   (mrg_slot),
    .entry_i  (mrg_entry),
    .sts_we_i (mrg_sts_we),
    .way_we_i (mrg_way_we),
    .line_o   (mrg_line),
    .strb_o   (mrg_strb)
  );

  // Next state and state-decoded handshake outputs.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    ar_valid_o  = 1'b0;
    r_ready_o   = 1'b0;
    b_ready_o   = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = cache_hit ? ST_WR : ST_AR;
      end
      ST_AR: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) state_d = ST_R;
      end
      ST_R: begin
        r_ready_o = 1'b1;
        if (r_valid_i) state_d = (r_resp_i != 2'b00) ? ST_DONE : ST_WR;
      end
      ST_WR: begin
        if ((!aw_pend_q || aw_ready_i) && (!w_pend_q || w_ready_i)) state_d = ST_B;
      end
      ST_B: begin
        b_ready_o = 1'b1;
        if (b_valid_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ar_addr_o  = addr_q;
  assign aw_addr_o  = addr_q;
  assign aw_valid_o = aw_pend_q;
  assign w_valid_o  = w_pend_q;
  assign w_data_o   = line_q;
  assign w_strb_o   = strb_q;

  // State register, request capture, merged line and per-channel write pending flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      entry_q   <= '0;
      sts_we_q  <= 1'b0;
      way_we_q  <= 1'b0;
      addr_q    <= '0;
      line_q    <= '0;
      strb_q    <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            id_q     <= req_att_id_i;
            entry_q  <= req_entry_i;
            sts_we_q <= req_sts_we_i;
            way_we_q <= req_way_we_i;
            addr_q   <= ADDR_W'(att_line_addr(req_att_id_i));
            err_q    <= 1'b0;
            if (cache_hit) begin
              line_q    <= mrg_line;
              strb_q    <= mrg_strb;
              aw_pend_q <= 1'b1;
              w_pend_q  <= 1'b1;
            end
          end
        end
        ST_R: begin
          if (r_valid_i) begin
            if (r_resp_i != 2'b00) begin
              err_q <= 1'b1;
            end else begin
              line_q    <= mrg_line;
              strb_q    <= mrg_strb;
              aw_pend_q <= 1'b1;
              w_pend_q  <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (aw_ready_i) aw_pend_q <= 1'b0;
          if (w_ready_i)  w_pend_q  <= 1'b0;
        end
        ST_B: begin
          if (b_valid_i) err_q <= (b_resp_i != 2'b00);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hawk_att_upd.sv
// Scoreboard bench for hawk_att_upd: expected write-back and completion
// pushed per request, compared as the engine produces them.
module tb_hawk_att_upd;

  localparam int          ID_W      = 11;
  localparam logic [63:0] ATT_START = 64'h0000_0000_8000_0000;
  localparam logic [63:0] STS_MASK  = 64'h0000_0000_0000_000F;
  localparam logic [63:0] WAY_MASK  = 64'h0000_0000_0000_0FF0;

  logic           clk_i;
  logic           rst_i;
  logic           req_valid_i, req_ready_o;
  logic [ID_W-1:0] req_att_id_i;
  logic [63:0]    req_entry_i;
  logic           req_sts_we_i, req_way_we_i;
  logic           done_o, err_o;
  logic           ar_valid_o, ar_ready_i;
  logic [63:0]    ar_addr_o;
  logic           r_valid_i, r_ready_o;
  logic [511:0]   r_data_i;
  logic [1:0]     r_resp_i;
  logic           aw_valid_o, aw_ready_i;
  logic [63:0]    aw_addr_o;
  logic           w_valid_o, w_ready_i;
  logic [511:0]   w_data_o;
  logic [63:0]    w_strb_o;
  logic           b_valid_i, b_ready_o;
  logic [1:0]     b_resp_i;

  hawk_att_upd dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_att_id_i(req_att_id_i), .req_entry_i(req_entry_i),
    .req_sts_we_i(req_sts_we_i), .req_way_we_i(req_way_we_i),
    .done_o(done_o), .err_o(err_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] wdata;
    logic [63:0]  strb;
    bit           err;
    bit           has_wr;
    bit           hit;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] mem [logic [63:0]];
  bit           bc_vld;
  logic [63:0]  bc_addr;
  int           n_cmp;
  int           n_bad;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input int id, input logic [63:0] entry, input bit swe, input bit wwe,
                         input logic [1:0] rresp, input logic [1:0] bresp,
                         input int awdly, input bit rst_at_b);
    exp_t         e;
    logic [511:0] rl;
    logic [63:0]  upd;
    int           s, cyc, ar_cnt, aw_cnt, w_cnt, wr_idx, dn_cnt;
    bit           fin;
    e.addr = ATT_START + (64'((id - 1) / 8) << 6);
    s      = (id - 1) % 8;
    rl     = mem.exists(e.addr) ? mem[e.addr] : '0;
`ifdef HAWK_ATT_UPD_LINE_CACHE_EN
    e.hit  = bc_vld && (bc_addr == e.addr);
`else
    e.hit  = 1'b0;
`endif
    e.has_wr = e.hit || (rresp == 2'b00);
    e.err    = !e.has_wr || (bresp != 2'b00);
    e.lat    = !e.has_wr ? 3 : ((e.hit ? 3 : 5) + awdly);
    upd = rl[64*s +: 64];
    if (swe) upd = (upd & ~STS_MASK) | (entry & STS_MASK);
    if (wwe) upd = (upd & ~WAY_MASK) | (entry & WAY_MASK);
    e.wdata = rl;
    e.wdata[64*s +: 64] = upd;
    e.strb  = 64'hFF << (8 * s);
    exp_q.push_back(e);

    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i  = 1'b1;
    req_att_id_i = ID_W'(id);
    req_entry_i  = entry;
    req_sts_we_i = swe;
    req_way_we_i = wwe;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    cyc = 1; fin = 1'b0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; wr_idx = 0; dn_cnt = 0;
    while (!fin && cyc < 60) begin
      if (ar_valid_o) begin
        if (ar_cnt == 0) chk("ar_addr", ar_addr_o, exp_q[0].addr);
        ar_cnt++;
      end
      r_valid_i = r_ready_o;
      r_data_i  = rl;
      r_resp_i  = rresp;
      if (aw_valid_o || w_valid_o) begin
        if (wr_idx == 0) begin
          chk("w_data", w_data_o, exp_q[0].wdata);
          chk("w_strb", w_strb_o, exp_q[0].strb);
          chk("aw_addr", aw_addr_o, exp_q[0].addr);
        end
        if (aw_valid_o) aw_cnt++;
        if (w_valid_o)  w_cnt++;
        aw_ready_i = (wr_idx >= awdly);
        wr_idx++;
      end
      if (b_ready_o && rst_at_b) begin
        rst_i = 1'b1;
        b_valid_i = 1'b0;
        #1;
        chk("rst_mid_ready", req_ready_o, 1);
        chk("rst_mid_b_ready", b_ready_o, 0);
        chk("rst_mid_aw_valid", aw_valid_o, 0);
        chk("rst_mid_w_valid", w_valid_o, 0);
        chk("rst_mid_ar_valid", ar_valid_o, 0);
        chk("rst_mid_done", done_o, 0);
        chk("rst_mid_w_strb", w_strb_o, 0);
        chk("rst_mid_w_data", w_data_o, 0);
        chk("rst_mid_addr", aw_addr_o, 0);
        void'(exp_q.pop_front());
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk_i);
          if (done_o) dn_cnt++;
        end
        chk("no_done_after_rst", dn_cnt, 0);
        chk("ready_after_rst", req_ready_o, 1);
        bc_vld = 1'b0;
        fin = 1'b1;
      end else begin
        b_valid_i = b_ready_o;
        b_resp_i  = bresp;
        if (done_o) begin
          e = exp_q.pop_front();
          chk("err", err_o, e.err);
          chk("latency", cyc, e.lat);
          chk("ar_count", ar_cnt, e.hit ? 0 : 1);
          chk("aw_valid_cycles", aw_cnt, e.has_wr ? awdly + 1 : 0);
          chk("w_valid_cycles", w_cnt, e.has_wr ? 1 : 0);
          if (e.has_wr && !e.err) begin
            mem[e.addr] = e.wdata;
            bc_vld  = 1'b1;
            bc_addr = e.addr;
          end else begin
            bc_vld = 1'b0;
          end
          fin = 1'b1;
        end
        @(negedge clk_i);
        cyc++;
      end
    end
    if (!fin) begin
      chk("timeout_done", 0, 1);
      void'(exp_q.pop_front());
      b_valid_i = 1'b0;
      r_valid_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_bad = 0; bc_vld = 1'b0; bc_addr = '0;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_att_id_i = '0; req_entry_i = '0;
    req_sts_we_i = 1'b0; req_way_we_i = 1'b0;
    ar_ready_i = 1'b1; aw_ready_i = 1'b1; w_ready_i = 1'b1;
    r_valid_i = 1'b0; r_data_i = '0; r_resp_i = 2'b00;
    b_valid_i = 1'b0; b_resp_i = 2'b00;
    repeat (3) @(negedge clk_i);
    chk("rst_ar_valid", ar_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_w_strb", w_strb_o, 0);
    chk("rst_ar_addr", ar_addr_o, 0);

    mem[ATT_START] = {64{8'hAA}};
    run_req(1, 64'h1234_5678_9ABC_DEF5, 1'b1, 1'b0, 2'b00, 2'b00, 0, 1'b0);
    mem[ATT_START + 64'h40] = {64{8'h5A}};
    run_req(9, 64'h0000_0000_0000_03C7, 1'b1, 1'b1, 2'b00, 2'b00, 0, 1'b0);
    run_req(16, 64'hFFFF_FFFF_FFFF_FE61, 1'b0, 1'b1, 2'b00, 2'b00, 0, 1'b0);
    mem[ATT_START + 64'h80] = {16{32'hCAFE_F00D}};
    run_req(17, 64'h0000_0000_0000_0FFF, 1'b1, 1'b1, 2'b10, 2'b00, 0, 1'b0);
    mem[ATT_START + 64'hC0] = {16{32'hDEAD_BEEF}};
    run_req(25, 64'h0000_0000_0000_0ABC, 1'b1, 1'b1, 2'b00, 2'b00, 3, 1'b0);
    mem[ATT_START + 64'h100] = {8{64'h0123_4567_89AB_CDEF}};
    run_req(33, 64'h0000_0000_0000_0FFF, 1'b0, 1'b0, 2'b00, 2'b00, 0, 1'b0);
    mem[ATT_START + 64'h140] = {16{32'h1357_9BDF}};
    run_req(41, 64'h0000_0000_0000_0005, 1'b1, 1'b0, 2'b00, 2'b10, 0, 1'b0);
    mem[ATT_START + 64'h180] = {16{32'h2468_ACE0}};
    run_req(49, 64'h0000_0000_0000_0007, 1'b1, 1'b1, 2'b00, 2'b00, 0, 1'b1);
    run_req(2, 64'h0000_0000_0000_0A1B, 1'b1, 1'b1, 2'b00, 2'b00, 0, 1'b0);
    run_req(3, 64'h0000_0000_0000_0C2D, 1'b1, 1'b1, 2'b00, 2'b00, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
